// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter and the camera capture block.
package dmem_pkg;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    CPU  = 2'd1,
    CAM  = 2'd2
  } rd_owner_t;

  localparam int DEFAULT_MAX_WAIT = 8;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of CPU, camera and memory-port signals around the data-memory arbiter.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_stall;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_rvalid;

  logic              cam_req;
  logic              cam_we;
  logic [ADDR_W-1:0] cam_addr;
  logic [DATA_W-1:0] cam_wdata;
  logic              cam_gnt;
  logic [DATA_W-1:0] cam_rdata;
  logic              cam_rvalid;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter side.
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_stall, cpu_rdata, cpu_rvalid,
    input  cam_req, cam_we, cam_addr, cam_wdata,
    output cam_gnt, cam_rdata, cam_rvalid,
    output mem_addr, mem_wdata, mem_we,
    input  mem_rdata
  );

  // Requesters and memory side.
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_stall, cpu_rdata, cpu_rvalid,
    output cam_req, cam_we, cam_addr, cam_wdata,
    input  cam_gnt, cam_rdata, cam_rvalid,
    input  mem_addr, mem_wdata, mem_we,
    output mem_rdata
  );

endinterface

// File: rtl/dmem_arbiter.sv
// Shares the data-memory port between the CPU (fixed priority) and the camera,
// with a starvation-forced camera grant and read data steered to its issuer.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = DEFAULT_MAX_WAIT,
  parameter int STAT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  dmem_arbiter_if.slave     bus,
  output logic [STAT_W-1:0] contention_cnt
);

  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

  logic              force_cam;
  logic              gnt_cam;
  logic              gnt_cpu;
  logic              denied;
  logic [7:0]        starve_q;
  rd_owner_t         rd_own_q;
  logic [STAT_W-1:0] contention_q;
  logic [ADDR_W-1:0] mux_addr;
  logic [DATA_W-1:0] mux_wdata;
  logic              mux_we;

  always_comb begin
    force_cam = bus.cam_req && (starve_q == WAIT_LIMIT);
    gnt_cam   = bus.cam_req && (!bus.cpu_req || force_cam);
    gnt_cpu   = bus.cpu_req && !gnt_cam;
    denied    = (bus.cpu_req && !gnt_cpu) || (bus.cam_req && !gnt_cam);
  end

  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    mux_addr  = '0;
    mux_wdata = '0;
    mux_we    = 1'b0;
    if (gnt_cpu) begin
      mux_addr  = bus.cpu_addr;
      mux_wdata = bus.cpu_wdata;
      mux_we    = bus.cpu_we;
    end else if (gnt_cam) begin
      mux_addr  = bus.cam_addr;
      mux_wdata = bus.cam_wdata;
      mux_we    = bus.cam_we;
    end
  end

  assign bus.mem_addr  = mux_addr;
  assign bus.mem_wdata = mux_wdata;
  assign bus.mem_we    = mux_we;

  assign bus.cpu_stall = bus.cpu_req && !gnt_cpu;
  assign bus.cam_gnt   = gnt_cam;

  // Memory returns data one cycle after the address, so the owner register lines up with it.
  assign bus.cpu_rvalid = (rd_own_q == CPU);
  assign bus.cam_rvalid = (rd_own_q == CAM);
  assign bus.cpu_rdata  = (rd_own_q == CPU) ? bus.mem_rdata : '0;
  assign bus.cam_rdata  = (rd_own_q == CAM) ? bus.mem_rdata : '0;

  assign contention_cnt = contention_q;

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_q     <= '0;
      rd_own_q     <= NONE;
      contention_q <= '0;
    end else begin
      if (gnt_cam || !bus.cam_req) begin
        starve_q <= '0;
      end else if (starve_q != WAIT_LIMIT) begin
        starve_q <= starve_q + 8'd1;
      end

      if (gnt_cpu && !bus.cpu_we) begin
        rd_own_q <= CPU;
      end else if (gnt_cam && !bus.cam_we) begin
        rd_own_q <= CAM;
      end else begin
        rd_own_q <= NONE;
      end

      if (denied && !(&contention_q)) begin
        contention_q <= contention_q + STAT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: vector table for grant/mux behaviour plus
// hand-written sequences for reads, starvation, reset and counter saturation.
module tb_dmem_arbiter;

  logic clk;
  logic reset;
  logic [15:0] cnt;
  logic [3:0]  cnt2;

  int checks = 0;
  int errors = 0;

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus2 ();

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(8), .STAT_W(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus.slave),
    .contention_cnt (cnt)
  );

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(8), .STAT_W(4)) dut2 (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus2.slave),
    .contention_cnt (cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word-addressed memory model: read data registered one cycle after the address.
  logic [31:0] mem_model [0:4095];
  always @(posedge clk) begin
    bus.mem_rdata <= mem_model[bus.mem_addr[13:2]];
    if (bus.mem_we) mem_model[bus.mem_addr[13:2]] = bus.mem_wdata;
  end
  assign bus2.mem_rdata = '0;

  typedef struct {
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cam_req;
    logic        cam_we;
    logic [31:0] cam_addr;
    logic [31:0] cam_wdata;
    logic        exp_stall;
    logic        exp_gnt;
    logic        exp_we;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_cpu(input logic req, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata);
    bus.cpu_req   = req;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
  endtask

  task automatic set_cam(input logic req, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata);
    bus.cam_req   = req;
    bus.cam_we    = we;
    bus.cam_addr  = addr;
    bus.cam_wdata = wdata;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem_model[i] = '0;
    mem_model[32'h10 >> 2] = 32'h1111_1111;
    mem_model[32'h20 >> 2] = 32'h2222_2222;

    vecs[0] = '{1'b1, 1'b0, 32'h100, 32'h5,  1'b0, 1'b0, 32'h0,    32'h0, 1'b0, 1'b0, 1'b0, 32'h100,  32'h5};
    vecs[1] = '{1'b1, 1'b1, 32'h104, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h104, 32'hA5A5A5A5};
    vecs[2] = '{1'b0, 1'b0, 32'h0,   32'h0,  1'b0, 1'b0, 32'h0,    32'h0, 1'b0, 1'b0, 1'b0, 32'h0,    32'h0};
    vecs[3] = '{1'b1, 1'b1, 32'h108, 32'h1,  1'b1, 1'b1, 32'h2000, 32'h2, 1'b0, 1'b0, 1'b1, 32'h108,  32'h1};
    vecs[4] = '{1'b1, 1'b0, 32'h10C, 32'h0,  1'b1, 1'b1, 32'h2000, 32'h2, 1'b0, 1'b0, 1'b0, 32'h10C,  32'h0};
    vecs[5] = '{1'b0, 1'b0, 32'h0,   32'h0,  1'b1, 1'b1, 32'h2000, 32'h2, 1'b0, 1'b1, 1'b1, 32'h2000, 32'h2};
    vecs[6] = '{1'b0, 1'b0, 32'h0,   32'h0,  1'b1, 1'b0, 32'h3000, 32'h0, 1'b0, 1'b1, 1'b0, 32'h3000, 32'h0};
    vecs[7] = '{1'b1, 1'b0, 32'h110, 32'h0,  1'b1, 1'b0, 32'h3004, 32'h0, 1'b0, 1'b0, 1'b0, 32'h110,  32'h0};
    vecs[8] = '{1'b0, 1'b0, 32'h0,   32'h0,  1'b0, 1'b0, 32'h0,    32'h0, 1'b0, 1'b0, 1'b0, 32'h0,    32'h0};

    reset = 1'b0;
    set_cpu(0, 0, 0, 0);
    set_cam(0, 0, 0, 0);
    bus2.cpu_req = 0; bus2.cpu_we = 1; bus2.cpu_addr = 32'h4; bus2.cpu_wdata = 0;
    bus2.cam_req = 0; bus2.cam_we = 1; bus2.cam_addr = 32'h8; bus2.cam_wdata = 0;

    // Reset state
    @(negedge clk);
    check("rst cpu_rvalid", bus.cpu_rvalid, 0);
    check("rst cam_rvalid", bus.cam_rvalid, 0);
    check("rst cnt", cnt, 0);
    check("rst cpu_stall", bus.cpu_stall, 0);
    check("rst cam_gnt", bus.cam_gnt, 0);
    check("rst mem_we", bus.mem_we, 0);
    check("rst mem_addr", bus.mem_addr, 0);
    next_cycle();
    reset = 1'b1;

    // CPU only: store then load
    set_cpu(1, 1, 32'h40, 32'hDEADBEEF);
    @(negedge clk);
    check("cpu st stall", bus.cpu_stall, 0);
    check("cpu st mem_we", bus.mem_we, 1);
    check("cpu st mem_addr", bus.mem_addr, 32'h40);
    check("cpu st mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
    next_cycle();
    set_cpu(1, 0, 32'h40, 32'h0);
    @(negedge clk);
    check("cpu ld stall", bus.cpu_stall, 0);
    check("cpu ld mem_we", bus.mem_we, 0);
    check("cpu ld early rvalid", bus.cpu_rvalid, 0);
    next_cycle();
    set_cpu(0, 0, 0, 0);
    @(negedge clk);
    check("cpu ld rvalid", bus.cpu_rvalid, 1);
    check("cpu ld rdata", bus.cpu_rdata, 32'hDEADBEEF);
    check("cpu ld cam_rvalid", bus.cam_rvalid, 0);
    next_cycle();
    @(negedge clk);
    check("cpu ld rvalid one cycle", bus.cpu_rvalid, 0);
    next_cycle();

    // Camera only: write
    set_cam(1, 1, 32'h1000, 32'h00FF00FF);
    @(negedge clk);
    check("cam wr gnt", bus.cam_gnt, 1);
    check("cam wr mem_we", bus.mem_we, 1);
    check("cam wr mem_addr", bus.mem_addr, 32'h1000);
    check("cam wr mem_wdata", bus.mem_wdata, 32'h00FF00FF);
    check("cam wr cnt", cnt, 0);
    next_cycle();
    set_cam(0, 0, 0, 0);
    @(negedge clk);
    check("cam wr stored", mem_model[32'h1000 >> 2], 32'h00FF00FF);
    check("cam wr cnt after", cnt, 0);
    next_cycle();

    // Grant / mux vector table
    for (int i = 0; i < 9; i++) begin
      set_cpu(vecs[i].cpu_req, vecs[i].cpu_we, vecs[i].cpu_addr, vecs[i].cpu_wdata);
      set_cam(vecs[i].cam_req, vecs[i].cam_we, vecs[i].cam_addr, vecs[i].cam_wdata);
      @(negedge clk);
      check($sformatf("vec%0d cpu_stall", i), bus.cpu_stall, vecs[i].exp_stall);
      check($sformatf("vec%0d cam_gnt", i),   bus.cam_gnt,   vecs[i].exp_gnt);
      check($sformatf("vec%0d mem_we", i),    bus.mem_we,    vecs[i].exp_we);
      check($sformatf("vec%0d mem_addr", i),  bus.mem_addr,  vecs[i].exp_addr);
      check($sformatf("vec%0d mem_wdata", i), bus.mem_wdata, vecs[i].exp_wdata);
      next_cycle();
    end

    // Reset asserted the cycle after a CPU read grant
    set_cpu(1, 0, 32'h10, 32'h0);
    @(negedge clk);
    check("rmr grant", bus.cpu_stall, 0);
    next_cycle();
    reset = 1'b0;
    set_cpu(0, 0, 0, 0);
    @(negedge clk);
    check("rmr cpu_rvalid in reset", bus.cpu_rvalid, 0);
    check("rmr cam_rvalid in reset", bus.cam_rvalid, 0);
    check("rmr cnt in reset", cnt, 0);
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    check("rmr cpu_rvalid after", bus.cpu_rvalid, 0);
    check("rmr cam_rvalid after", bus.cam_rvalid, 0);
    check("rmr cnt after", cnt, 0);
    check("rmr starve after", dut.starve_q, 0);
    next_cycle();

    // Continuous contention: CPU 8 cycles, forced camera on the 9th, repeating
    set_cpu(1, 1, 32'h200, 32'hC0C0);
    set_cam(1, 1, 32'h2100, 32'hCAFE);
    for (int c = 1; c <= 18; c++) begin
      logic g;
      g = (c % 9 == 0);
      @(negedge clk);
      check($sformatf("cont%0d cam_gnt", c),   bus.cam_gnt, g);
      check($sformatf("cont%0d cpu_stall", c), bus.cpu_stall, g);
      check($sformatf("cont%0d mem_addr", c),  bus.mem_addr, g ? 32'h2100 : 32'h200);
      check($sformatf("cont%0d cnt", c),       cnt, c - 1);
      next_cycle();
    end
    set_cpu(0, 0, 0, 0);
    set_cam(0, 0, 0, 0);
    @(negedge clk);
    check("cont cnt final", cnt, 18);
    next_cycle();

    // Interleaved reads: CPU on n, camera on n+1
    set_cpu(1, 0, 32'h10, 32'h0);
    @(negedge clk);
    check("il n cpu_stall", bus.cpu_stall, 0);
    check("il n mem_addr", bus.mem_addr, 32'h10);
    next_cycle();
    set_cpu(0, 0, 0, 0);
    set_cam(1, 0, 32'h20, 32'h0);
    @(negedge clk);
    check("il n+1 cam_gnt", bus.cam_gnt, 1);
    check("il n+1 cpu_rvalid", bus.cpu_rvalid, 1);
    check("il n+1 cpu_rdata", bus.cpu_rdata, 32'h1111_1111);
    check("il n+1 cam_rvalid", bus.cam_rvalid, 0);
    check("il n+1 cam_rdata", bus.cam_rdata, 0);
    next_cycle();
    set_cam(0, 0, 0, 0);
    @(negedge clk);
    check("il n+2 cam_rvalid", bus.cam_rvalid, 1);
    check("il n+2 cam_rdata", bus.cam_rdata, 32'h2222_2222);
    check("il n+2 cpu_rvalid", bus.cpu_rvalid, 0);
    check("il n+2 cpu_rdata", bus.cpu_rdata, 0);
    next_cycle();
    @(negedge clk);
    check("il n+3 cpu_rvalid", bus.cpu_rvalid, 0);
    check("il n+3 cam_rvalid", bus.cam_rvalid, 0);
    next_cycle();

    // Saturation of a 4-bit contention counter
    bus2.cpu_req = 1;
    bus2.cam_req = 1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      check($sformatf("sat%0d cnt", c), cnt2, (c - 1 > 15) ? 15 : c - 1);
      next_cycle();
    end
    @(negedge clk);
    check("sat hold", cnt2, 15);
    bus2.cpu_req = 0;
    bus2.cam_req = 0;
    next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter that shares the single data-memory port of `mem_controller` between the ARM pipeline's load/store stage and the camera pixel writer. CPU has fixed priority. A starvation counter forces a camera grant after a bounded wait. Read data is steered back to the requester that issued the read. It sits between `arm`/camera capture logic and port A of `mem_controller`, and drives the pipeline stall for memory contention.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `MAX_WAIT`, 8, consecutive denied camera-request cycles before a forced camera grant; legal range 1..255
- `STAT_W`, 16, width of the saturating contention counter

Ports:
- `clk`  in  1  single clock; all state on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `cpu_req`  in  1  CPU memory access request (load or store)
- `cpu_we`  in  1  1 = store, 0 = load
- `cpu_addr`  in  ADDR_W  CPU byte address
- `cpu_wdata`  in  DATA_W  CPU store data
- `cpu_stall`  out  1  CPU request present but not granted this cycle
- `cpu_rdata`  out  DATA_W  load data
- `cpu_rvalid`  out  1  `cpu_rdata` valid (one cycle)
- `cam_req`  in  1  camera access request; held until granted
- `cam_we`  in  1  1 = write pixel word, 0 = read
- `cam_addr`  in  ADDR_W  camera address
- `cam_wdata`  in  DATA_W  camera write data
- `cam_gnt`  out  1  camera request accepted this cycle
- `cam_rdata`  out  DATA_W  camera read data
- `cam_rvalid`  out  1  `cam_rdata` valid (one cycle)
- `mem_addr`  out  ADDR_W  to memory port
- `mem_wdata`  out  DATA_W  to memory port
- `mem_we`  out  1  to memory port
- `mem_rdata`  in  DATA_W  memory read data, valid one cycle after address
- `contention_cnt`  out  STAT_W  cycles in which a request was denied, saturating

## Operation
Grant decision is combinational from requests and `starve_q`:
- `force = cam_req && starve_q == MAX_WAIT`.
- `gnt_cam = cam_req && (!cpu_req || force)`.
- `gnt_cpu = cpu_req && !gnt_cam`.
- At most one grant per cycle.

Memory mux:
- Selected requester's addr/wdata/we drive the `mem_*` outputs.
- With no grant: `mem_we = 0`, `mem_addr`/`mem_wdata` = 0.

Outputs:
- `cpu_stall = cpu_req && !gnt_cpu`.
- `cam_gnt = gnt_cam`.

Starvation counter `starve_q` (8 bits):
- Clears on `gnt_cam` or `!cam_req`.
- Otherwise increments, and never exceeds `MAX_WAIT`.

Read steering:
- Register `rd_own_q` ∈ {NONE, CPU, CAM} captures the owner of a granted read (`we = 0`).
- Next cycle, `<owner>_rvalid = 1` and `<owner>_rdata = mem_rdata`.
- The non-owner's rdata is 0.

Contention counter:
- `contention_cnt` increments when `cpu_stall || (cam_req && !gnt_cam)`.
- It saturates at all-ones.

## Timing
- Reset (async assert, sync release): `starve_q = 0`, `rd_own_q = NONE`, `cpu_rvalid = 0`, `cam_rvalid = 0`, `contention_cnt = 0`. Combinational outputs follow the reset-state equations.
- Write latency: 0 cycles. The memory samples the write at the edge ending the grant cycle.
- Read latency: data and rvalid appear exactly 1 cycle after the grant cycle.
- Back-to-back reads from alternating owners are legal; each rvalid is in its own cycle.
- A requester holds `req`, `addr`, `we` and `wdata` stable until granted. The CPU holds them through `cpu_stall` via the pipeline freeze.
- Forced grant lasts exactly one cycle, then `starve_q` clears.
- Worst-case camera wait is therefore `MAX_WAIT` cycles. The CPU is stalled at most 1 cycle per `MAX_WAIT+1`.
- Simultaneous requests with `starve_q < MAX_WAIT`: the CPU wins.
- `cam_req` dropping mid-wait clears `starve_q`. This is legal but not expected.
- Reset mid-read: a pending rvalid is discarded and not presented after release.

## Structure
- Shared package `dmem_pkg`: `rd_owner_t` enum (NONE, CPU, CAM) and a default `MAX_WAIT` constant. The package is reused by the camera capture block.
- Single module, no sub-modules.
- A saturating counter is small enough to inline; do not create a separate counter module.

## Test plan
- **CPU only:** store `0xDEADBEEF` to `0x40`, then load `0x40`.
  - `cpu_stall` stays 0.
  - `cpu_rvalid` pulses 1 cycle after the load grant, with `cpu_rdata = 0xDEADBEEF`.
- **Camera only:** write `0x00FF00FF` to `0x1000`.
  - `cam_gnt` in the same cycle, `mem_we = 1`, `contention_cnt` stays 0.
- **Contention:** `cpu_req` and `cam_req` held high continuously, `MAX_WAIT = 8`.
  - CPU granted 8 cycles, camera forced on cycle 9 with `cpu_stall = 1` that cycle, then the pattern repeats.
  - `contention_cnt` increments every cycle.
- **Interleaved reads:** CPU read of `0x10` on cycle n, camera read of `0x20` on cycle n+1.
  - `cpu_rvalid` on n+1 and `cam_rvalid` on n+2, each with correct data.
  - The other port's rvalid is 0 in each of those cycles.
- **Reset mid-read:** assert `reset` low in the cycle after a CPU read grant.
  - All rvalids are 0.
  - After release, no spurious rvalid; `contention_cnt = 0`, `starve_q = 0`.
- **Saturation:** `STAT_W = 4`, 20 contended cycles.
  - `contention_cnt` holds at 15.
